// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: LSU state encoding, funct3 size codes
// and byte-enable masks.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_H_LO = 4'b0011;
   localparam logic [3:0] BE_H_HI = 4'b1100;
   localparam logic [3:0] BE_W    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store replication, byte enables, alignment check,
// and load shift plus sign/zero extension.
module lsu_align
   import cpu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_addr,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic        st_illegal,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_addr,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_result
);

   logic [31:0] shifted;

   // Each lane picks the byte that lands on it for the access size.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam int HSEL = 8 * (gi % 2);
         assign st_wdata[8*gi +: 8] =
            (st_funct3[1:0] == 2'b00) ? st_data[7:0] :
            (st_funct3[1:0] == 2'b01) ? st_data[HSEL +: 8] :
                                        st_data[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      st_be = BE_W;
      case (st_funct3[1:0])
         2'b00:   st_be = BE_B0 << st_addr;
         2'b01:   st_be = st_addr[1] ? BE_H_HI : BE_H_LO;
         default: st_be = BE_W;
      endcase
   end

   always_comb begin
      st_illegal = 1'b1;
      case (st_funct3)
         F3_B, F3_BU: st_illegal = 1'b0;
         F3_H, F3_HU: st_illegal = st_addr[0];
         F3_W:        st_illegal = (st_addr != 2'b00);
         default:     st_illegal = 1'b1;
      endcase
   end

   assign shifted = ld_rdata >> {ld_addr, 3'b000};

   always_comb begin
      ld_result = shifted;
      case (ld_funct3)
         F3_B:    ld_result = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ld_result = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ld_result = {24'h0, shifted[7:0]};
         F3_HU:   ld_result = {16'h0, shifted[15:0]};
         default: ld_result = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: issues loads/stores on a req/gnt/rvalid bus, stalls the pipeline
// while an access is outstanding and rejects misaligned accesses without bus traffic.
module load_store_unit
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_valid,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] ALUout,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [4:0]            rd_in,
   output logic                  stall,
   output logic                  wb_valid,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [4:0]            rd_out,
   output logic                  misaligned,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   output logic [3:0]            bus_be,
   input  logic                  bus_gnt,
   input  logic                  bus_rvalid,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   lsu_state_t            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [2:0]            f3_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [3:0]            be_reg;
   logic [4:0]            rd_reg;
   logic                  is_load_reg;
   logic                  mis_reg;
   logic [DATA_WIDTH-1:0] load_data_reg;
   logic [4:0]            rd_out_reg;

   logic                  accept;
   logic [DATA_WIDTH-1:0] st_wdata;
   logic [3:0]            st_be;
   logic                  st_illegal;
   logic [DATA_WIDTH-1:0] ld_result;

   // Store formatting uses the incoming instruction; load extension uses the latched one.
   lsu_align u_align (
      .st_funct3  (funct3),
      .st_addr    (ALUout[1:0]),
      .st_data    (store_data),
      .st_wdata   (st_wdata),
      .st_be      (st_be),
      .st_illegal (st_illegal),
      .ld_funct3  (f3_reg),
      .ld_addr    (addr_reg[1:0]),
      .ld_rdata   (bus_rdata),
      .ld_result  (ld_result)
   );

   assign accept = (state_reg == ST_IDLE) & ex_valid & (mem_read | mem_write);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (accept) state_next = st_illegal ? ST_RESP : ST_REQ;
         ST_REQ:  if (bus_gnt) state_next = is_load_reg ? ST_WAIT : ST_RESP;
         ST_WAIT: if (bus_rvalid) state_next = ST_RESP;
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         addr_reg      <= '0;
         f3_reg        <= '0;
         wdata_reg     <= '0;
         be_reg        <= '0;
         rd_reg        <= '0;
         is_load_reg   <= 1'b0;
         mis_reg       <= 1'b0;
         load_data_reg <= '0;
         rd_out_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg    <= ALUout;
            f3_reg      <= funct3;
            wdata_reg   <= st_wdata;
            be_reg      <= mem_read ? BE_NONE : st_be;
            rd_reg      <= rd_in;
            is_load_reg <= mem_read;
            mis_reg     <= st_illegal;
         end
         // A store completion clears the load result; misaligned accesses leave it untouched.
         if ((state_reg == ST_REQ) && bus_gnt && !is_load_reg) begin
            load_data_reg <= '0;
            rd_out_reg    <= '0;
         end
         if ((state_reg == ST_WAIT) && bus_rvalid) begin
            load_data_reg <= ld_result;
            rd_out_reg    <= rd_reg;
         end
      end
   end

   assign bus_req    = (state_reg == ST_REQ);
   assign bus_we     = bus_req & ~is_load_reg;
   assign bus_addr   = bus_req ? {addr_reg[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign bus_wdata  = bus_we ? wdata_reg : '0;
   assign bus_be     = bus_we ? be_reg : BE_NONE;
   assign wb_valid   = (state_reg == ST_RESP) & ~mis_reg;
   assign misaligned = (state_reg == ST_RESP) & mis_reg;
   assign load_data  = load_data_reg;
   assign rd_out     = rd_out_reg;
   assign stall      = (state_reg == ST_REQ) | (state_reg == ST_WAIT) | (accept & ~st_illegal);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses on a zero-wait bus,
// plus hand-written sequences for a slow bus and reset during an outstanding load.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] ALUout, store_data;
   logic [4:0]  rd_in;
   logic        stall, wb_valid, misaligned;
   logic [31:0] load_data;
   logic [4:0]  rd_out;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt, bus_rvalid;
   logic [31:0] bus_rdata;

   int checks = 0;
   int failures = 0;
   logic [31:0] last_ld = '0;
   logic [4:0]  last_rd = '0;

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .ALUout(ALUout), .store_data(store_data),
      .rd_in(rd_in), .stall(stall), .wb_valid(wb_valid), .load_data(load_data),
      .rd_out(rd_out), .misaligned(misaligned), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [4:0]  rd_idx;
      logic [31:0] rdata;
      logic        mis;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] ld;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_vec(input vec_t t, input string nm);
      @(negedge clk);
      ex_valid = 1'b1; mem_read = t.rd; mem_write = t.wr; funct3 = t.f3;
      ALUout = t.addr; store_data = t.sdata; rd_in = t.rd_idx;
      #1;
      chk({nm, "_stall_accept"}, 32'(stall), 32'(!t.mis));
      chk({nm, "_noreq_accept"}, 32'(bus_req), 32'd0);
      @(negedge clk);
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      if (t.mis) begin
         chk({nm, "_misaligned"}, 32'(misaligned), 32'd1);
         chk({nm, "_no_wb"}, 32'(wb_valid), 32'd0);
         chk({nm, "_no_req"}, 32'(bus_req), 32'd0);
         chk({nm, "_no_stall"}, 32'(stall), 32'd0);
         chk({nm, "_ld_hold"}, load_data, last_ld);
         chk({nm, "_rd_hold"}, 32'(rd_out), 32'(last_rd));
      end else begin
         chk({nm, "_req"}, 32'(bus_req), 32'd1);
         chk({nm, "_we"}, 32'(bus_we), 32'(t.wr & ~t.rd));
         chk({nm, "_addr"}, bus_addr, {t.addr[31:2], 2'b00});
         chk({nm, "_be"}, 32'(bus_be), 32'(t.be));
         if (!t.rd) chk({nm, "_wdata"}, bus_wdata, t.wdata);
         chk({nm, "_stall_req"}, 32'(stall), 32'd1);
         bus_gnt = 1'b1;
         @(negedge clk);
         bus_gnt = 1'b0;
         if (t.rd) begin
            chk({nm, "_wait_noreq"}, 32'(bus_req), 32'd0);
            chk({nm, "_stall_wait"}, 32'(stall), 32'd1);
            chk({nm, "_wait_nowb"}, 32'(wb_valid), 32'd0);
            bus_rvalid = 1'b1; bus_rdata = t.rdata;
            @(negedge clk);
            bus_rvalid = 1'b0; bus_rdata = '0;
         end
         chk({nm, "_wb"}, 32'(wb_valid), 32'd1);
         chk({nm, "_stall_resp"}, 32'(stall), 32'd0);
         chk({nm, "_load_data"}, load_data, t.rd ? t.ld : 32'd0);
         if (t.rd) begin
            chk({nm, "_rd_out"}, 32'(rd_out), 32'(t.rd_idx));
            last_rd = t.rd_idx;
         end
         last_ld = t.rd ? t.ld : 32'd0;
      end
      @(negedge clk);
      chk({nm, "_wb_one_cycle"}, 32'(wb_valid), 32'd0);
      chk({nm, "_mis_one_cycle"}, 32'(misaligned), 32'd0);
      $display("txn %s rd=%0d wr=%0d f3=%03b addr=0x%08h load_data=0x%08h rd_out=%0d",
               nm, t.rd, t.wr, t.f3, t.addr, load_data, rd_out);
   endtask

   initial begin
      // rd wr f3 addr sdata rd_idx rdata mis be wdata ld
      vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234BEEF, 5'd0, 32'h0, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 5'd5, 32'h0080FF00, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF80};
      vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 5'd6, 32'h0080FF00, 1'b0, 4'b0000, 32'h0, 32'h00000080};
      vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 32'h80010000, 1'b0, 4'b0000, 32'h0, 32'hFFFF8001};
      vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 5'd8, 32'h1234F00D, 1'b0, 4'b0000, 32'h0, 32'h0000F00D};
      vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5'd31, 32'hCAFEBABE, 1'b0, 4'b0000, 32'h0, 32'hCAFEBABE};
      vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd9, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h102, 32'h11111111, 5'd0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd10, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 5'd11, 32'h00007F00, 1'b0, 4'b0000, 32'h0, 32'h0000007F};
      vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h108, 32'h0, 5'd12, 32'h11223344, 1'b0, 4'b0000, 32'h0, 32'h11223344};

      rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
      ALUout = '0; store_data = '0; rd_in = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_wb", 32'(wb_valid), 32'd0);
      chk("reset_req", 32'(bus_req), 32'd0);
      chk("reset_load_data", load_data, 32'd0);
      chk("reset_rd_out", 32'(rd_out), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

      // Slow bus: grant on the 4th REQ cycle, rvalid two cycles after the grant.
      @(negedge clk);
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
      ALUout = 32'h10C; rd_in = 5'd9;
      #1 chk("slow_stall_accept", 32'(stall), 32'd1);
      @(negedge clk);
      ex_valid = 1'b0; mem_read = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("slow_req_c%0d", k), 32'(bus_req), 32'd1);
         chk($sformatf("slow_addr_c%0d", k), bus_addr, 32'h10C);
         chk($sformatf("slow_stall_c%0d", k), 32'(stall), 32'd1);
         bus_rvalid = (k == 1);
         bus_rdata  = (k == 1) ? 32'hBAD0BAD0 : 32'h0;
         bus_gnt    = (k == 3);
      end
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      chk("slow_wait1_noreq", 32'(bus_req), 32'd0);
      chk("slow_wait1_stall", 32'(stall), 32'd1);
      chk("slow_wait1_nowb", 32'(wb_valid), 32'd0);
      @(negedge clk);
      chk("slow_wait2_stall", 32'(stall), 32'd1);
      chk("slow_wait2_nowb", 32'(wb_valid), 32'd0);
      bus_rvalid = 1'b1; bus_rdata = 32'h89ABCDEF;
      @(negedge clk);
      bus_rvalid = 1'b0; bus_rdata = '0;
      chk("slow_wb", 32'(wb_valid), 32'd1);
      chk("slow_load_data", load_data, 32'h89ABCDEF);
      chk("slow_rd_out", 32'(rd_out), 32'd9);
      @(negedge clk);
      chk("slow_wb_once", 32'(wb_valid), 32'd0);
      $display("txn slow_lw addr=0x0000010c load_data=0x%08h rd_out=%0d", load_data, rd_out);

      // Reset while a load sits in WAIT; late rvalid must not complete anything.
      @(negedge clk);
      ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; ALUout = 32'h110; rd_in = 5'd3;
      @(negedge clk);
      ex_valid = 1'b0; mem_read = 1'b0; bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk("rst_wait_stall", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb", 32'(wb_valid), 32'd0);
      chk("rst_mis", 32'(misaligned), 32'd0);
      chk("rst_req", 32'(bus_req), 32'd0);
      chk("rst_we", 32'(bus_we), 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_be", 32'(bus_be), 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_rd_out", 32'(rd_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
      @(negedge clk);
      bus_rvalid = 1'b0; bus_rdata = '0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_after_nowb_c%0d", k), 32'(wb_valid), 32'd0);
         chk($sformatf("rst_after_ld_c%0d", k), load_data, 32'd0);
         @(negedge clk);
      end
      $display("txn reset_in_wait load_data=0x%08h wb_valid=%0d", load_data, wb_valid);
      last_ld = '0; last_rd = '0;
      do_vec('{1'b1, 1'b0, 3'b010, 32'h114, 32'h0, 5'd4, 32'h0BADF00D, 1'b0, 4'b0000, 32'h0, 32'h0BADF00D},
             "post_reset_lw");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
